// File: rtl/dh_pkg.sv
// Shared types and constants for the duck-hunt round controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dh_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        FLIGHT,
        RESULT,
        ROUND_END,
        GAME_OVER
    } round_state_t;

    // Score bonus awarded to every player after a perfect round.
    localparam logic [3:0] PERFECT_BONUS = 4'd10;

    // Largest supported number of shooter channels; sets the winner index width.
    localparam int MAX_PLAYERS = 4;
    localparam int WIN_W       = $clog2(MAX_PLAYERS);

endpackage

// File: rtl/bcd_sat_add.sv
// Two-digit BCD plus 4-bit binary addend, saturating at 99.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure function of its inputs.
//
// Ports:
//   a_bcd   in  8  two BCD digits, tens in [7:4]
//   addend  in  4  binary increment 0..15
//   sum_bcd out 8  min(a + addend, 99) as two BCD digits
module bcd_sat_add (
    input  logic [7:0] a_bcd,
    input  logic [3:0] addend,
    output logic [7:0] sum_bcd
);

    logic [7:0] a_bin;
    logic [7:0] s_bin;
    logic [6:0] sat;

    // Converting through binary keeps the carry handling trivial; the operand
    // range (<= 180) fits comfortably in 8 bits.
    always_comb begin
        a_bin   = 8'(a_bcd[7:4]) * 8'd10 + 8'(a_bcd[3:0]);
        s_bin   = a_bin + 8'(addend);
        sat     = (s_bin > 8'd99) ? 7'd99 : s_bin[6:0];
        sum_bcd = {4'(sat / 7'd10), 4'(sat % 7'd10)};
    end

endmodule

// File: rtl/ctl_round.sv
// Round/duck sequencer for a duck-hunt game: ammo, hits, scores, rounds.
// Latency: registered outputs update one cycle after their cause.
// Backpressure: none; pause freezes all state, game_start always restarts.
//
// Ports:
//   clk, rst (sync, active-high), new_frame (frame strobe), game_start,
//   pause, shot_fired[N], hit[N], duck_escaped                -> inputs
//   duck_launch (pulse), duck_hit, fly_away, winner, ammo (4b/player),
//   score_bcd (8b/player), round_bcd, duck_idx, game_over    -> outputs
//
// Build option: define CTL_ROUND_PERFECT_BONUS_EN to award PERFECT_BONUS to
// every player when all ducks of a round were hit.
module ctl_round
    import dh_pkg::*;
#(
    parameter int N_PLAYERS       = 2,
    parameter int AMMO_PER_DUCK   = 3,
    parameter int DUCKS_PER_ROUND = 10,
    parameter int PASS_HITS       = 6,
    parameter int GAP_FRAMES      = 60
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   new_frame,
    input  logic                   game_start,
    input  logic                   pause,
    input  logic [N_PLAYERS-1:0]   shot_fired,
    input  logic [N_PLAYERS-1:0]   hit,
    input  logic                   duck_escaped,
    output logic                   duck_launch,
    output logic                   duck_hit,
    output logic                   fly_away,
    output logic [WIN_W-1:0]       winner,
    output logic [4*N_PLAYERS-1:0] ammo,
    output logic [8*N_PLAYERS-1:0] score_bcd,
    output logic [7:0]             round_bcd,
    output logic [3:0]             duck_idx,
    output logic                   game_over
);

    round_state_t state_q, state_d;

    logic [3:0]       ammo_q     [N_PLAYERS];
    logic [3:0]       ammo_d     [N_PLAYERS];
    logic [7:0]       score_q    [N_PLAYERS];
    logic [7:0]       score_sum  [N_PLAYERS];
    logic [3:0]       score_add  [N_PLAYERS];
    logic [7:0]       round_q;
    logic [7:0]       round_sum;
    logic [3:0]       round_add;
    logic [3:0]       duck_idx_q;
    logic [3:0]       round_hits_q;
    logic [7:0]       frame_cnt_q;
    logic             duck_hit_q;
    logic             fly_away_q;
    logic [WIN_W-1:0] winner_q;

    logic             run;
    logic             hit_any;
    logic [WIN_W-1:0] win_idx;
    logic             ammo_out;
    logic             gap_done;
    logic             last_duck;
    logic             round_pass;

    assign run        = !pause;
    assign last_duck  = (duck_idx_q == 4'(DUCKS_PER_ROUND - 1));
    assign gap_done   = new_frame && (frame_cnt_q == 8'(GAP_FRAMES - 1));
    assign round_pass = (round_hits_q >= 4'(PASS_HITS));

    // Shot/hit decode. Eligibility uses the ammo held before this cycle's
    // shots. Scanning downwards leaves the lowest eligible player as winner.
    always_comb begin
        hit_any  = 1'b0;
        win_idx  = '0;
        ammo_out = 1'b1;
        for (int p = N_PLAYERS - 1; p >= 0; p--) begin
            ammo_d[p] = ammo_q[p];
            if (ammo_q[p] != 4'd0) begin
                if (shot_fired[p]) begin
                    ammo_d[p] = ammo_q[p] - 4'd1;
                end
                if (hit[p]) begin
                    hit_any = 1'b1;
                    win_idx = WIN_W'(p);
                end
            end
            if (ammo_d[p] != 4'd0) begin
                ammo_out = 1'b0;
            end
        end
    end

`ifdef CTL_ROUND_PERFECT_BONUS_EN
    logic perfect;
    assign perfect = (round_hits_q == 4'(DUCKS_PER_ROUND));
`endif

    // Adder operands. A perfect round always passes, so the bonus lands on
    // the same edge that advances the round.
    always_comb begin
        for (int p = 0; p < N_PLAYERS; p++) begin
            score_add[p] = 4'd0;
            if (run && state_q == FLIGHT && hit_any && win_idx == WIN_W'(p)) begin
                score_add[p] = 4'd1;
            end
`ifdef CTL_ROUND_PERFECT_BONUS_EN
            if (run && state_q == ROUND_END && perfect) begin
                score_add[p] = PERFECT_BONUS;
            end
`endif
        end
        round_add = (run && state_q == ROUND_END && round_pass) ? 4'd1 : 4'd0;
    end

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        bcd_sat_add u_score (
            .a_bcd   (score_q[p]),
            .addend  (score_add[p]),
            .sum_bcd (score_sum[p])
        );
        assign ammo[4*p +: 4]      = ammo_q[p];
        assign score_bcd[8*p +: 8] = score_q[p];
    end

    bcd_sat_add u_round (
        .a_bcd   (round_q),
        .addend  (round_add),
        .sum_bcd (round_sum)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; game_start wins over pause from any state.
    always_comb begin
        state_d = state_q;
        if (game_start) begin
            state_d = LAUNCH;
        end else if (run) begin
            case (state_q)
                LAUNCH:    state_d = FLIGHT;
                FLIGHT:    if (hit_any || ammo_out || duck_escaped) state_d = RESULT;
                RESULT:    if (gap_done) state_d = last_duck ? ROUND_END : LAUNCH;
                ROUND_END: state_d = round_pass ? LAUNCH : GAME_OVER;
                default:   state_d = state_q;
            endcase
        end
    end

    // Output decode. The launch pulse is held back while paused so a pause
    // spanning LAUNCH still yields exactly one launch cycle.
    always_comb begin
        duck_launch = (state_q == LAUNCH) && !pause;
        game_over   = (state_q == GAME_OVER);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                ammo_q[p]  <= 4'd0;
                score_q[p] <= 8'h00;
            end
            round_q      <= 8'h01;
            duck_idx_q   <= 4'd0;
            round_hits_q <= 4'd0;
            frame_cnt_q  <= 8'd0;
            duck_hit_q   <= 1'b0;
            fly_away_q   <= 1'b0;
            winner_q     <= '0;
        end else if (game_start) begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                score_q[p] <= 8'h00;
            end
            round_q      <= 8'h01;
            duck_idx_q   <= 4'd0;
            round_hits_q <= 4'd0;
            frame_cnt_q  <= 8'd0;
        end else if (run) begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                score_q[p] <= score_sum[p];
            end
            round_q <= round_sum;
            case (state_q)
                LAUNCH: begin
                    for (int p = 0; p < N_PLAYERS; p++) begin
                        ammo_q[p] <= 4'(AMMO_PER_DUCK);
                    end
                    duck_hit_q  <= 1'b0;
                    fly_away_q  <= 1'b0;
                    frame_cnt_q <= 8'd0;
                end
                FLIGHT: begin
                    for (int p = 0; p < N_PLAYERS; p++) begin
                        ammo_q[p] <= ammo_d[p];
                    end
                    if (hit_any) begin
                        duck_hit_q   <= 1'b1;
                        winner_q     <= win_idx;
                        round_hits_q <= round_hits_q + 4'd1;
                    end else if (ammo_out) begin
                        fly_away_q <= 1'b1;
                    end
                end
                RESULT: begin
                    if (gap_done) begin
                        frame_cnt_q <= 8'd0;
                        if (!last_duck) begin
                            duck_idx_q <= duck_idx_q + 4'd1;
                        end
                    end else if (new_frame) begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                    end
                end
                ROUND_END: begin
                    if (round_pass) begin
                        duck_idx_q   <= 4'd0;
                        round_hits_q <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign duck_hit  = duck_hit_q;
    assign fly_away  = fly_away_q;
    assign winner    = winner_q;
    assign round_bcd = round_q;
    assign duck_idx  = duck_idx_q;

endmodule

// File: doc/ctl_round.md
CTL_ROUND -- requirements
Module: ctl_round

Interface
REQ-001 Parameter N_PLAYERS, default 2: number of shooter channels, legal range 1..4.
REQ-002 Parameter AMMO_PER_DUCK, default 3: shots each player gets per duck, legal range 1..9.
REQ-003 Parameter DUCKS_PER_ROUND, default 10: ducks per round, legal range 1..15.
REQ-004 Parameter PASS_HITS, default 6: round hits needed to advance, legal range 1..DUCKS_PER_ROUND.
REQ-005 Parameter GAP_FRAMES, default 60: frames held in RESULT, legal range 1..255.
REQ-006 Ports, in order:
- clk  in  1  main 65 MHz clock
- rst  in  1  synchronous, active-high reset
- new_frame  in  1  one-cycle frame strobe
- game_start  in  1  start or restart the game
- pause  in  1  freeze level
- shot_fired  in  N_PLAYERS  per-player shot pulse
- hit  in  N_PLAYERS  per-player hit pulse
- duck_escaped  in  1  duck left the screen
- duck_launch  out  1  one-cycle launch pulse to the duck controller
- duck_hit  out  1  level, high while the current duck is hit
- fly_away  out  1  level, all ammo spent
- winner  out  2  index of the player who hit the current duck
- ammo  out  4*N_PLAYERS  binary remaining shots, player p at bits [4p+3:4p]
- score_bcd  out  8*N_PLAYERS  two BCD digits per player
- round_bcd  out  8  two BCD digits, current round
- duck_idx  out  4  current duck, 0-based
- game_over  out  1  level

Function
REQ-007 States: IDLE, LAUNCH, FLIGHT, RESULT, ROUND_END, GAME_OVER.
REQ-008 IDLE -> LAUNCH on game_start: scores 00, round 01, duck_idx 0, round_hits 0.
REQ-009 LAUNCH, one cycle: ammo reloads to AMMO_PER_DUCK for every player; duck_launch pulses; duck_hit and fly_away clear; next state FLIGHT.
REQ-010 FLIGHT, shot_fired[p] with ammo[p] > 0: ammo[p] decrements next cycle. shot_fired[p] with ammo[p] = 0 is ignored.
REQ-011 FLIGHT, any hit[p] with ammo[p] > 0 (checked before this cycle's decrement):
- duck_hit set, winner = lowest such p
- score[winner] +1 in BCD, saturating at 99
- round_hits +1
- next state RESULT
REQ-012 FLIGHT, a hit and a shot in the same cycle: both act; the hit takes priority over ammo exhaustion.
REQ-013 FLIGHT, all ammo reaches 0 with no hit: fly_away set, next state RESULT.
REQ-014 FLIGHT, duck_escaped with no hit: next state RESULT, fly_away stays 0.
REQ-015 RESULT: GAP_FRAMES new_frame strobes are counted, then:
- if duck_idx = DUCKS_PER_ROUND-1: next state ROUND_END
- otherwise duck_idx +1, next state LAUNCH
REQ-016 ROUND_END, one cycle:
- round_hits >= PASS_HITS: round +1 BCD (saturating at 99), duck_idx 0, round_hits 0, next state LAUNCH
- otherwise: next state GAME_OVER
REQ-017 GAME_OVER: game_over = 1; scores hold; game_start -> IDLE-equivalent restart straight into LAUNCH.
REQ-018 pause = 1: state, all counters and the frame counter freeze, and shot/hit inputs are ignored. game_start is still honoured.
REQ-019 game_start in any state other than IDLE and GAME_OVER restarts the game, as in REQ-008.
REQ-020 Registered outputs change on the cycle after their cause (latency 1).

Reset
REQ-021 On rst, next clock edge, all of the following take effect; rst overrides game_start and pause:
- state IDLE
- duck_launch = 0, duck_hit = 0, fly_away = 0, winner = 0
- ammo = 0, score_bcd = 0, round_bcd = 0x01, duck_idx = 0, game_over = 0

Configuration
REQ-022 With macro CTL_ROUND_PERFECT_BONUS_EN defined: in ROUND_END, if round_hits = DUCKS_PER_ROUND, every player's score gains PERFECT_BONUS (BCD, saturating at 99) before the round advances.
REQ-023 Without CTL_ROUND_PERFECT_BONUS_EN: no bonus logic is present and ROUND_END behaves per REQ-016 only.

Structure
REQ-024 Package dh_pkg holds:
- round_state_t enum
- PERFECT_BONUS = 10
- MAX_PLAYERS = 4
REQ-025 Sub-module bcd_sat_add: two-digit BCD plus a 4-bit binary addend, saturating at 99. Each score and round_bcd uses one instance.

Verification
REQ-026 Player 0 hits at ammo 3 -> score_bcd[7:0] = 0x01, winner = 0, ammo[3:0] = 3, RESULT.
REQ-027 3 shots from every player, no hits -> fly_away = 1; a 4th shot leaves ammo = 0.
REQ-028 hit = 2'b11 in the same cycle -> winner = 0; only player 0's score increments.
REQ-029 10 ducks with 5 hits, PASS_HITS = 6 -> game_over = 1, round_bcd = 0x01. With 6 hits -> round_bcd = 0x02, no game_over.
REQ-030 Score at 0x99 plus a hit -> stays 0x99. With the macro and 10/10 hits -> every score +10, saturating.
REQ-031 rst pulsed during FLIGHT -> all REQ-021 values appear on the next cycle. pause held for 200 frames in RESULT -> no state change.
